shmem_port_master: RTL and testbench
====================================

# shmem_port_master

Client-side controller for one port of the shared-memory arbiter interface. It takes a valid/ready command stream of single-word reads and writes and drives one port's `shmem_request`/`shmem_wren`/`shmem_addr`/`shmem_datain` slice. It waits for that port's `shmem_done`, captures `shmem_dataout` after the fixed memory read latency, and returns read data on a valid/ready response stream. One instance sits in front of each arbiter port.

## Interface

**Parameters**
- `ADDR_WIDTH`, 12, address width of one port.
- `DATA_WIDTH`, 32, data width of one port.
- `READ_LATENCY`, 1, cycles from `shmem_done` high to valid `shmem_dataout`. Legal range 0..3. Use 1 for registered memory outputs with a 1-cycle RAM.

**Ports**
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock; everything is sampled on the rising edge.
- `srst` in 1: asynchronous active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_wren` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: word address.
- `cmd_data` in DATA_WIDTH: write data; ignored for reads.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data` out DATA_WIDTH: read data.
- `shmem_request` out 1: access request to the arbiter.
- `shmem_wren` out 1: write enable for the current access.
- `shmem_addr` out ADDR_WIDTH: address for the current access.
- `shmem_datain` out DATA_WIDTH: write data for the current access.
- `shmem_dataout` in DATA_WIDTH: read data from the arbiter.
- `shmem_done` in 1: the access presented on the previous cycle was performed.
- `busy` out 1: high in every state except IDLE.

## Operation

- **Outstanding accesses:** at most one access is in flight.
- **Command register:**
  - `shmem_wren`, `shmem_addr` and `shmem_datain` come from a register loaded on command acceptance.
  - The register is held stable until `shmem_done`.
- **Request gating:** `shmem_request = req_q & ~shmem_done`, combinational.
  - The mask is mandatory. The arbiter samples the request on the done cycle, and an unmasked request would produce a duplicate access.
- **States:**
  - **IDLE:** `cmd_ready=1`. On accept, load the command, set `req_q`, go to REQ.
  - **REQ:** wait for `shmem_done`. On done, clear `req_q`.
    - Write: go to IDLE.
    - Read with `READ_LATENCY=0`: capture `shmem_dataout` this cycle, go to RSP.
    - Read otherwise: load the latency counter with `READ_LATENCY-1`, go to WAIT.
  - **WAIT:** decrement the counter. When it reaches 0, capture `shmem_dataout` into `rsp_data` and go to RSP.
  - **RSP:** `rsp_valid=1`, `rsp_data` held. On `rsp_ready`, go to IDLE.
- **Back-pressure:** `cmd_ready` is low in REQ, WAIT and RSP, so an unconsumed response blocks further commands.
- **Spurious done:** `shmem_done` seen in IDLE, WAIT or RSP is ignored.
- **Reset values:**
  - State IDLE; `req_q=0`, so `shmem_request=0`.
  - `shmem_wren=0`, `shmem_addr=0`, `shmem_datain=0`.
  - `rsp_valid=0`, `rsp_data=0`, `busy=0`, counter 0.
- **Reset mid-operation:** `shmem_request` drops asynchronously and any pending response is discarded. The arbiter's own reset is independent and needs no coordination.

## Timing

- **Command to request:** command accepted at edge N; `shmem_request` is high from cycle N+1.
- **Arbitration:** the arbiter samples the request while its round-robin state points at this port (cycle T) and asserts `shmem_done` at T+1. At T+1 the request is masked low.
- **Write throughput:** `cmd_ready` is back in IDLE at T+2, so the minimum write period is 3 cycles per access with no contention.
- **Read latency:** `rsp_valid` rises at T+1+`READ_LATENCY`+1 edge-aligned, i.e. `READ_LATENCY` cycles after done plus one capture cycle.
- **Simultaneous handshakes:** a response handshake and a command offer in the same cycle do not overlap. The command is accepted the following cycle in IDLE.

## Structure

- Shared include `shmem_defs`:
  - State encodings (`SHM_IDLE`, `SHM_REQ`, `SHM_WAIT`, `SHM_RSP`; 2-bit localparams).
  - Counter width: 2 bits, covering `READ_LATENCY` up to 3.
- Single module with no sub-module. The latency counter is inline.
- The `READ_LATENCY=0` path is selected with a generate-if.

## Test plan

1. **Write with arbiter model:** arbiter model (4 ports, this one is port 2) idle; write cmd addr 0x0A5, data 0xDEADBEEF → `shmem_request` high 1 cycle before done, with addr/data stable; exactly one memory write; `cmd_ready` back 1 cycle after done.
2. **Read:** read addr 0x0A5 with `READ_LATENCY=1` → `rsp_data`=0xDEADBEEF, `rsp_valid` 2 cycles after done.
3. **Contention:** three other ports request continuously → done arrives within 4 arbitration cycles; no duplicate access (memory write count = 1).
4. **Back-pressure:** hold `rsp_ready=0` for 10 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready=0`, no new request. Release → handshake, then next command accepted.
5. **Reset mid-read:** assert `srst` in WAIT → `shmem_request`, `rsp_valid` and `busy` are 0 immediately; after release, a fresh read of 0x001 returns correct data.
6. **Zero latency:** `READ_LATENCY=0` with back-to-back reads of 0x000..0x00F → data matches the memory model, one response per command, in order.

Source files
------------

// File: rtl/shmem_port_master_pkg.sv
// ---------------------------------------------------------------------------
// shmem_port_master_pkg
//
// Shared definitions for the shared-memory port master:
//   - shmState_e : controller state encodings (2-bit)
//   - SHM_CNT_W  : width of the read-latency counter (covers latencies 0..3)
//   - latencyLoad: value loaded into the latency counter when a read's done
//                  arrives, for a given fixed memory read latency
// ---------------------------------------------------------------------------
package shmem_port_master_pkg;

  // Controller states. IDLE accepts commands, REQ holds the request until
  // the arbiter reports done, WAIT covers the memory read latency, and RSP
  // presents read data until the consumer takes it.
  typedef enum logic [1:0] {
    SHM_IDLE = 2'd0,
    SHM_REQ  = 2'd1,
    SHM_WAIT = 2'd2,
    SHM_RSP  = 2'd3
  } shmState_e;

  // Two bits are enough for the largest supported read latency of 3.
  localparam int SHM_CNT_W = 2;

  // Largest read latency the counter can represent.
  localparam int SHM_MAX_READ_LATENCY = 3;

  // The WAIT state captures data when the counter is already zero, so a
  // latency of L needs L-1 loaded on the done cycle. Latency 0 bypasses
  // WAIT entirely and never uses this value.
  function automatic logic [SHM_CNT_W-1:0] latencyLoad(input int readLatency);
    if (readLatency > 0) begin
      return SHM_CNT_W'(readLatency - 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/shmem_port_master.sv
// ---------------------------------------------------------------------------
// shmem_port_master
//
// Client-side controller for one port of the shared-memory arbiter. Accepts
// single-word read/write commands on a valid/ready stream, presents them to
// the arbiter one at a time, waits for done, collects read data after the
// fixed memory read latency and returns it on a valid/ready response stream.
//
// Parameters
//   ADDR_WIDTH   : word address width of one port
//   DATA_WIDTH   : data width of one port
//   READ_LATENCY : cycles from shmem_done to valid shmem_dataout (0..3)
//
// Ports
//   clk, srst            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_wren/addr/data   : command contents (data ignored for reads)
//   rsp_valid/rsp_ready  : read response handshake
//   rsp_data             : read data
//   shmem_request        : access request to the arbiter (masked by done)
//   shmem_wren/addr/datain : registered access attributes
//   shmem_dataout        : read data from the arbiter
//   shmem_done           : previous cycle's access was performed
//   busy                 : controller is not idle
// ---------------------------------------------------------------------------
module shmem_port_master
  import shmem_port_master_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  srst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wren,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,

  output logic                  shmem_request,
  output logic                  shmem_wren,
  output logic [ADDR_WIDTH-1:0] shmem_addr,
  output logic [DATA_WIDTH-1:0] shmem_datain,
  input  logic [DATA_WIDTH-1:0] shmem_dataout,
  input  logic                  shmem_done,

  output logic                  busy
);

  shmState_e             state_q,   state_d;
  logic                  req_q,     req_d;
  logic                  wren_q,    wren_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] datain_q,  datain_d;
  logic [DATA_WIDTH-1:0] rspData_q, rspData_d;
  logic [SHM_CNT_W-1:0]  latCnt_q,  latCnt_d;

  // How a read completes once done arrives: with zero latency the data is
  // already on shmem_dataout during the done cycle, otherwise the counter
  // is loaded and WAIT covers the remaining cycles.
  logic                  captureOnDone;
  logic [SHM_CNT_W-1:0]  latLoad;

  if (READ_LATENCY == 0) begin : gZeroLatency
    assign captureOnDone = 1'b1;
    assign latLoad       = '0;
  end else begin : gPipeLatency
    assign captureOnDone = 1'b0;
    assign latLoad       = latencyLoad(READ_LATENCY);
  end

  // State and datapath registers. Reset clears req_q asynchronously, which
  // drops shmem_request immediately and discards any pending response.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q   <= SHM_IDLE;
      req_q     <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
      datain_q  <= '0;
      rspData_q <= '0;
      latCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
      datain_q  <= datain_d;
      rspData_q <= rspData_d;
      latCnt_q  <= latCnt_d;
    end
  end

  // Next-state logic. The command register is only loaded in IDLE, so the
  // access attributes stay stable for the whole REQ phase. Done outside
  // REQ is not acted upon, so a stray done cannot disturb the sequence.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wren_d    = wren_q;
    addr_d    = addr_q;
    datain_d  = datain_q;
    rspData_d = rspData_q;
    latCnt_d  = latCnt_q;

    case (state_q)
      SHM_IDLE: begin
        if (cmd_valid) begin
          wren_d   = cmd_wren;
          addr_d   = cmd_addr;
          datain_d = cmd_data;
          req_d    = 1'b1;
          state_d  = SHM_REQ;
        end
      end

      SHM_REQ: begin
        if (shmem_done) begin
          req_d = 1'b0;
          if (wren_q) begin
            state_d = SHM_IDLE;
          end else if (captureOnDone) begin
            rspData_d = shmem_dataout;
            state_d   = SHM_RSP;
          end else begin
            latCnt_d = latLoad;
            state_d  = SHM_WAIT;
          end
        end
      end

      SHM_WAIT: begin
        if (latCnt_q == '0) begin
          rspData_d = shmem_dataout;
          state_d   = SHM_RSP;
        end else begin
          latCnt_d = latCnt_q - 1'b1;
        end
      end

      SHM_RSP: begin
        if (rsp_ready) begin
          state_d = SHM_IDLE;
        end
      end

      default: begin
        state_d = SHM_IDLE;
      end
    endcase
  end

  // The arbiter samples the request on the done cycle as well, so the
  // request must be masked there or the same access would be granted twice.
  assign shmem_request = req_q & ~shmem_done;
  assign shmem_wren    = wren_q;
  assign shmem_addr    = addr_q;
  assign shmem_datain  = datain_q;

  assign cmd_ready = (state_q == SHM_IDLE);
  assign rsp_valid = (state_q == SHM_RSP);
  assign rsp_data  = rspData_q;
  assign busy      = (state_q != SHM_IDLE);

endmodule

// File: tb/tb_shmem_port_master.sv
// ---------------------------------------------------------------------------
// tb_shmem_port_master
//
// Directed bench for shmem_port_master. One instance (READ_LATENCY=1) sits
// on port 2 of a 4-port round-robin arbiter model backed by a small memory;
// a second instance (READ_LATENCY=0) talks to a dedicated single-port model
// that grants every request immediately.
// ---------------------------------------------------------------------------
module tb_shmem_port_master;

  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic srst;

  // Clock with a 10-time-unit period; inputs change and outputs are
  // observed on the falling edge, away from the active edge.
  always #5 clk = ~clk;

  // Instance with one cycle of read latency, on arbiter port 2.
  logic          cmdValid, cmdReady, cmdWren;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdData;
  logic          rspValid, rspReady;
  logic [DW-1:0] rspData;
  logic          shmRequest, shmWren, shmDone, busy;
  logic [AW-1:0] shmAddr;
  logic [DW-1:0] shmDatain, shmDataout;

  // Instance with zero read latency, on its own port model.
  logic          zCmdValid, zCmdReady, zCmdWren;
  logic [AW-1:0] zCmdAddr;
  logic [DW-1:0] zCmdData;
  logic          zRspValid, zRspReady;
  logic [DW-1:0] zRspData;
  logic          zRequest, zWren, zDone, zBusy;
  logic [AW-1:0] zAddr;
  logic [DW-1:0] zDatain, zDataout;

  shmem_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .srst(srst),
    .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_wren(cmdWren),
    .cmd_addr(cmdAddr), .cmd_data(cmdData),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_data(rspData),
    .shmem_request(shmRequest), .shmem_wren(shmWren), .shmem_addr(shmAddr),
    .shmem_datain(shmDatain), .shmem_dataout(shmDataout), .shmem_done(shmDone),
    .busy(busy)
  );

  shmem_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(0)) dutZero (
    .clk(clk), .srst(srst),
    .cmd_valid(zCmdValid), .cmd_ready(zCmdReady), .cmd_wren(zCmdWren),
    .cmd_addr(zCmdAddr), .cmd_data(zCmdData),
    .rsp_valid(zRspValid), .rsp_ready(zRspReady), .rsp_data(zRspData),
    .shmem_request(zRequest), .shmem_wren(zWren), .shmem_addr(zAddr),
    .shmem_datain(zDatain), .shmem_dataout(zDataout), .shmem_done(zDone),
    .busy(zBusy)
  );

  // Power-on memory contents, also restored by reset.
  function automatic logic [31:0] initVal(input logic [7:0] a);
    return {24'hC0DE00, a};
  endfunction

  // Memory and 4-port round-robin arbiter model. The pointer advances every
  // cycle; when it points at a requesting port that port is granted. A grant
  // to port 2 performs the access and raises done on the next cycle. Read
  // data appears on the done cycle and is delayed once more to give the
  // one-cycle read latency seen by the main instance.
  logic [31:0] mem [0:255];
  logic [1:0]  rrPtr;
  logic [2:0]  otherReq;
  logic [3:0]  portReq;
  logic [31:0] rdStage1, rdStage2;
  int          writeCount;
  int          otherGrants;

  assign portReq    = {otherReq[2], shmRequest, otherReq[1], otherReq[0]};
  assign shmDataout = rdStage2;

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      rrPtr       <= 2'd0;
      shmDone     <= 1'b0;
      rdStage1    <= '0;
      rdStage2    <= '0;
      writeCount  <= 0;
      otherGrants <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= initVal(i[7:0]);
    end else begin
      shmDone  <= 1'b0;
      rdStage2 <= rdStage1;
      if (portReq[rrPtr]) begin
        if (rrPtr == 2'd2) begin
          shmDone <= 1'b1;
          if (shmWren) begin
            mem[shmAddr[7:0]] <= shmDatain;
            writeCount        <= writeCount + 1;
          end else begin
            rdStage1 <= mem[shmAddr[7:0]];
          end
        end else begin
          otherGrants <= otherGrants + 1;
        end
      end
      rrPtr <= rrPtr + 2'd1;
    end
  end

  // Dedicated port model for the zero-latency instance: every request is
  // granted at once and the read data is valid on the done cycle.
  logic [31:0] zRd;
  int          zRspCount;

  assign zDataout = zRd;

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      zDone     <= 1'b0;
      zRd       <= '0;
      zRspCount <= 0;
    end else begin
      zDone <= zRequest;
      if (zRequest) zRd <= mem[zAddr[7:0]];
      if (zRspValid && zRspReady) zRspCount <= zRspCount + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offer one command on the main instance and let it be accepted on the
  // next rising edge; returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic wren, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data);
    checkOutput("cmdReadyBeforeAccept", cmdReady, 1);
    cmdValid = 1'b1;
    cmdWren  = wren;
    cmdAddr  = addr;
    cmdData  = data;
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  // Wait (bounded) for done on the main instance.
  task automatic waitDone(input string tag, output int cyc);
    cyc = 0;
    while (!shmDone && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, shmDone, 1);
  endtask

  // Wait (bounded) for a response, check its data and consume it.
  task automatic collectRead(input string tag, input logic [DW-1:0] expected);
    int cyc = 0;
    while (!rspValid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, " rspValid"}, rspValid, 1);
    checkOutput({tag, " rspData"}, rspData, expected);
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput({tag, " rspConsumed"}, rspValid, 0);
  endtask

  initial begin
    int cyc;
    int wcBefore;

    // Watchdog so the run always reaches an end.
    fork
      begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    srst      = 1'b1;
    cmdValid  = 1'b0; cmdWren = 1'b0; cmdAddr = '0; cmdData = '0;
    rspReady  = 1'b0;
    otherReq  = 3'b000;
    zCmdValid = 1'b0; zCmdWren = 1'b0; zCmdAddr = '0; zCmdData = '0;
    zRspReady = 1'b1;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst cmdReady",   cmdReady,   1);
    checkOutput("rst request",    shmRequest, 0);
    checkOutput("rst wren",       shmWren,    0);
    checkOutput("rst addr",       shmAddr,    0);
    checkOutput("rst datain",     shmDatain,  0);
    checkOutput("rst rspValid",   rspValid,   0);
    checkOutput("rst rspData",    rspData,    0);
    checkOutput("rst busy",       busy,       0);
    checkOutput("rst zDatain",    zDatain,    0);
    srst = 1'b0;
    @(negedge clk);

    // Write through the arbiter, no contention.
    $display("[TB] write 0x0A5");
    applyStimulus(1'b1, 12'h0A5, 32'hDEADBEEF);
    checkOutput("t1 busy", busy, 1);
    checkOutput("t1 cmdReadyLow", cmdReady, 0);
    cyc = 0;
    while (!shmDone && cyc < 8) begin
      checkOutput("t1 reqHigh",    shmRequest, 1);
      checkOutput("t1 wrenStable", shmWren,    1);
      checkOutput("t1 addrStable", shmAddr,    32'h0A5);
      checkOutput("t1 dataStable", shmDatain,  32'hDEADBEEF);
      @(negedge clk);
      cyc++;
    end
    checkOutput("t1 doneSeen",  shmDone,    1);
    checkOutput("t1 reqMasked", shmRequest, 0);
    checkOutput("t1 notReadyOnDone", cmdReady, 0);
    @(negedge clk);
    checkOutput("t1 cmdReadyBack", cmdReady,   1);
    checkOutput("t1 idleBusy",     busy,       0);
    checkOutput("t1 reqLow",       shmRequest, 0);
    repeat (3) @(negedge clk);
    checkOutput("t1 writeCount", writeCount,  1);
    checkOutput("t1 memWord",    mem[8'hA5],  32'hDEADBEEF);

    // Read back with one cycle of latency.
    $display("[TB] read 0x0A5");
    applyStimulus(1'b0, 12'h0A5, 32'h0);
    waitDone("t2 done", cyc);
    @(negedge clk);
    checkOutput("t2 notYetValid", rspValid, 0);
    @(negedge clk);
    checkOutput("t2 validTwoAfterDone", rspValid, 1);
    collectRead("t2", 32'hDEADBEEF);

    // Contention from the three other ports.
    $display("[TB] contention write");
    otherReq = 3'b111;
    wcBefore = writeCount;
    applyStimulus(1'b1, 12'h010, 32'h12345678);
    waitDone("t3 done", cyc);
    checkOutput("t3 doneWithin4", (cyc <= 4) ? 1 : 0, 1);
    repeat (6) @(negedge clk);
    checkOutput("t3 singleWrite", writeCount - wcBefore, 1);
    checkOutput("t3 memWord",     mem[8'h10], 32'h12345678);
    checkOutput("t3 othersServed", (otherGrants > 0) ? 1 : 0, 1);
    otherReq = 3'b000;

    // Back-pressure on the response with a command waiting.
    $display("[TB] back-pressure");
    applyStimulus(1'b0, 12'h010, 32'h0);
    cyc = 0;
    while (!rspValid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t4 rspArrived", rspValid, 1);
    cmdValid = 1'b1; cmdWren = 1'b0; cmdAddr = 12'h002; cmdData = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("t4 holdValid",  rspValid,   1);
      checkOutput("t4 holdData",   rspData,    32'h12345678);
      checkOutput("t4 holdNotRdy", cmdReady,   0);
      checkOutput("t4 holdNoReq",  shmRequest, 0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    rspReady = 1'b0;
    checkOutput("t4 rspTaken",    rspValid, 0);
    checkOutput("t4 idleAfterRsp", cmdReady, 1);
    checkOutput("t4 notBusy",     busy,     0);
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("t4 nextAccepted", busy,      1);
    checkOutput("t4 nextAddr",     shmAddr,   32'h002);
    checkOutput("t4 nextReq",      shmRequest, 1);
    collectRead("t4 next", initVal(8'h02));

    // Reset while the request is outstanding, then while in WAIT.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 12'h004, 32'h0);
    checkOutput("t5 reqBefore", shmRequest, 1);
    srst = 1'b1;
    #1;
    checkOutput("t5 reqDropReq",  shmRequest, 0);
    checkOutput("t5 busyDropReq", busy,       0);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 12'h003, 32'h0);
    waitDone("t5 done", cyc);
    @(negedge clk);
    checkOutput("t5 inWait",      busy,     1);
    checkOutput("t5 waitNoValid", rspValid, 0);
    srst = 1'b1;
    #1;
    checkOutput("t5 reqAfterRst",   shmRequest, 0);
    checkOutput("t5 validAfterRst", rspValid,   0);
    checkOutput("t5 busyAfterRst",  busy,       0);
    checkOutput("t5 dataAfterRst",  rspData,    0);
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    checkOutput("t5 noStaleRsp", rspValid, 0);
    applyStimulus(1'b0, 12'h001, 32'h0);
    collectRead("t5 fresh", initVal(8'h01));

    // Zero-latency instance, back-to-back reads of 0x000..0x00F.
    $display("[TB] zero-latency reads");
    for (int i = 0; i < 16; i++) begin
      cyc = 0;
      while (!zCmdReady && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("t6 cmdReady", zCmdReady, 1);
      zCmdValid = 1'b1;
      zCmdAddr  = AW'(i);
      @(negedge clk);
      zCmdValid = 1'b0;
      cyc = 0;
      while (!zDone && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("t6 done", zDone, 1);
      checkOutput("t6 wren", zWren, 0);
      @(negedge clk);
      checkOutput("t6 rspValid", zRspValid, 1);
      checkOutput("t6 rspData",  zRspData,  initVal(8'(i)));
    end
    repeat (3) @(negedge clk);
    checkOutput("t6 rspCount", zRspCount, 16);
    checkOutput("t6 idle",     zBusy,     0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
